// File: rtl/bec_pkg.sv
// Shared types and constants for the BEC logic-analyser test sequencer.
package bec_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned STATUS_W = 16;
  localparam int unsigned TID_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_PROC,
    S_WRITE,
    S_RESULT,
    S_FINISH
  } state_t;

  // Progress codes shown on the GPIO checkbits
  localparam logic [STATUS_W-1:0] ST_RESET  = 16'h0000;
  localparam logic [STATUS_W-1:0] ST_START  = 16'hAB40;
  localparam logic [STATUS_W-1:0] ST_READ   = 16'hAB41;
  localparam logic [STATUS_W-1:0] ST_PROC   = 16'hAB42;
  localparam logic [STATUS_W-1:0] ST_WRITE  = 16'hAB51;
  localparam logic [STATUS_W-1:0] ST_PASS   = 16'hAB43;
  localparam logic [STATUS_W-1:0] ST_FAIL   = 16'hAB44;
  localparam logic [STATUS_W-1:0] ST_FINISH = 16'hABFF;

endpackage

// File: rtl/bec_la_hs.sv
// 4-phase req/ack word handshake engine, used for both transfer directions.
// dir_wr=0: CPU offers a word (req), block accepts (take_c) and raises ack.
// dir_wr=1: block presents a word (take_c) with ack, CPU consumes with req.
module bec_la_hs (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic dir_wr,
  input  logic req,
  output logic ack,
  output logic take_c,
  output logic done_c
);

  // Set once the CPU has consumed the presented word, until it drops req
  logic held;

  // Phase decode: when to capture/present a word and when a word completes
  always_comb begin
    take_c = 1'b0;
    done_c = 1'b0;
    if (en && !clr) begin
      if (!dir_wr) begin
        take_c = req && !ack;
        done_c = !req && ack;
      end else begin
        take_c = !ack && !held;
        done_c = held && !req;
      end
    end
  end

  // Handshake state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack  <= 1'b0;
      held <= 1'b0;
    end else if (clr) begin
      ack  <= 1'b0;
      held <= 1'b0;
    end else if (en) begin
      if (!dir_wr) begin
        if (take_c)      ack <= 1'b1;
        else if (done_c) ack <= 1'b0;
      end else begin
        if (take_c) begin
          ack <= 1'b1;
        end else if (ack && req) begin
          ack  <= 1'b0;
          held <= 1'b1;
        end else if (done_c) begin
          held <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/bec_la_seq.sv
// Test sequencer: loads operands from the CPU, runs the BEC core, returns results.
module bec_la_seq
  import bec_pkg::*;
#(
  parameter int unsigned N_IN_WORDS     = 8,
  parameter int unsigned N_OUT_WORDS    = 4,
  parameter int unsigned N_TESTS        = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                la_start_i,
  input  logic                la_abort_i,
  input  logic                la_req_i,
  output logic                la_ack_o,
  input  logic [DATA_W-1:0]   la_data_i,
  output logic [DATA_W-1:0]   la_data_o,
  output logic [STATUS_W-1:0] status_o,
  output logic [TID_W-1:0]    test_id_o,
  output logic                op_wr_en_o,
  output logic [ADDR_W-1:0]   op_addr_o,
  output logic [DATA_W-1:0]   op_wdata_o,
  output logic                core_start_o,
  input  logic                core_done_i,
  input  logic                core_err_i,
  output logic [ADDR_W-1:0]   res_addr_o,
  input  logic [DATA_W-1:0]   res_rdata_i
);

  localparam int unsigned MAX_WORDS = (N_IN_WORDS > N_OUT_WORDS) ? N_IN_WORDS : N_OUT_WORDS;
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d, cnt_inc_c;
  logic [TMO_W-1:0]    cyc, cyc_d;
  logic                fail, fail_d;
  logic                start_q;
  logic [STATUS_W-1:0] status_d;
  logic [TID_W-1:0]    tid_d;
  logic [DATA_W-1:0]   data_d, wdata_d;
  logic [ADDR_W-1:0]   op_addr_d;
  logic                wr_en_d, core_start_d;
  logic                abort_c, start_rise_c;
  logic                hs_en_c, hs_dir_wr_c, hs_take_c, hs_done_c;

  assign abort_c      = la_abort_i && (state inside {S_START, S_READ, S_PROC, S_WRITE});
  assign start_rise_c = la_start_i && !start_q;
  assign cnt_inc_c    = cnt + CNT_W'(1);
  assign hs_en_c      = (state == S_READ) || (state == S_WRITE);
  assign hs_dir_wr_c  = (state == S_WRITE);
  assign res_addr_o   = ADDR_W'(cnt);

  bec_la_hs u_hs (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (abort_c),
    .en     (hs_en_c),
    .dir_wr (hs_dir_wr_c),
    .req    (la_req_i),
    .ack    (la_ack_o),
    .take_c (hs_take_c),
    .done_c (hs_done_c)
  );

  // Next-state and next-output decode; abort overrides every transition
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    cyc_d        = cyc;
    fail_d       = fail;
    status_d     = status_o;
    tid_d        = test_id_o;
    data_d       = la_data_o;
    wr_en_d      = 1'b0;
    op_addr_d    = op_addr_o;
    wdata_d      = op_wdata_o;
    core_start_d = 1'b0;
    if (abort_c) begin
      state_d  = S_IDLE;
      status_d = ST_FAIL;
      cnt_d    = '0;
      cyc_d    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_rise_c) begin
            state_d  = S_START;
            status_d = ST_START;
          end
        end
        S_START: begin
          state_d  = S_READ;
          status_d = ST_READ;
          cnt_d    = '0;
          fail_d   = 1'b0;
        end
        S_READ: begin
          if (hs_take_c) begin
            wr_en_d   = 1'b1;
            op_addr_d = ADDR_W'(cnt);
            wdata_d   = la_data_i;
          end
          if (hs_done_c) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(N_IN_WORDS)) begin
              state_d      = S_PROC;
              status_d     = ST_PROC;
              cnt_d        = '0;
              cyc_d        = '0;
              core_start_d = 1'b1;
            end
          end
        end
        S_PROC: begin
          if (core_done_i) begin
            if (core_err_i) begin
              fail_d  = 1'b1;
              state_d = S_RESULT;
            end else begin
              state_d  = S_WRITE;
              status_d = ST_WRITE;
              cnt_d    = '0;
            end
          end else if (cyc == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            fail_d  = 1'b1;
            state_d = S_RESULT;
          end else begin
            cyc_d = cyc + TMO_W'(1);
          end
        end
        S_WRITE: begin
          if (hs_take_c) data_d = res_rdata_i;
          if (hs_done_c) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(N_OUT_WORDS)) state_d = S_RESULT;
          end
        end
        S_RESULT: begin
          if (test_id_o == TID_W'(N_TESTS - 1)) begin
            state_d  = S_FINISH;
            status_d = ST_FINISH;
          end else begin
            state_d = S_IDLE;
            tid_d   = test_id_o + TID_W'(1);
          end
        end
        S_FINISH: begin
          state_d = S_FINISH;
        end
        default: state_d = S_IDLE;
      endcase
      if (state_d == S_RESULT && state != S_RESULT) status_d = fail_d ? ST_FAIL : ST_PASS;
    end
  end

  // State and registered outputs; start detector primed high so a held start is ignored
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cyc          <= '0;
      fail         <= 1'b0;
      start_q      <= 1'b1;
      status_o     <= ST_RESET;
      test_id_o    <= '0;
      la_data_o    <= '0;
      op_wr_en_o   <= 1'b0;
      op_addr_o    <= '0;
      op_wdata_o   <= '0;
      core_start_o <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      cyc          <= cyc_d;
      fail         <= fail_d;
      start_q      <= la_start_i;
      status_o     <= status_d;
      test_id_o    <= tid_d;
      la_data_o    <= data_d;
      op_wr_en_o   <= wr_en_d;
      op_addr_o    <= op_addr_d;
      op_wdata_o   <= wdata_d;
      core_start_o <= core_start_d;
    end
  end

endmodule

// File: tb/tb_bec_la_seq.sv
// Self-checking bench for bec_la_seq: CPU/core behavioural models plus expected-value tracking.
module tb_bec_la_seq;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned N_OUT = 4;
  localparam int unsigned N_T   = 2;
  localparam int unsigned TMO   = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        la_start, la_abort, la_req, la_ack;
  logic [31:0] la_data_i, la_data_o;
  logic [15:0] status;
  logic [7:0]  test_id;
  logic        op_wr_en, core_start, core_done, core_err;
  logic [3:0]  op_addr, res_addr;
  logic [31:0] op_wdata, res_rdata;

  always #5 clk = ~clk;

  bec_la_seq #(
    .N_IN_WORDS     (N_IN),
    .N_OUT_WORDS    (N_OUT),
    .N_TESTS        (N_T),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .la_start_i   (la_start),
    .la_abort_i   (la_abort),
    .la_req_i     (la_req),
    .la_ack_o     (la_ack),
    .la_data_i    (la_data_i),
    .la_data_o    (la_data_o),
    .status_o     (status),
    .test_id_o    (test_id),
    .op_wr_en_o   (op_wr_en),
    .op_addr_o    (op_addr),
    .op_wdata_o   (op_wdata),
    .core_start_o (core_start),
    .core_done_i  (core_done),
    .core_err_i   (core_err),
    .res_addr_o   (res_addr),
    .res_rdata_i  (res_rdata)
  );

  // Core result memory model: combinational read
  logic [31:0] in_words [N_IN];
  logic [31:0] res_mem  [16];
  assign res_rdata = res_mem[res_addr];

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          exp_tid = 0;
  logic [15:0] last_st = 16'h0000;
  logic [15:0] st_q[$];
  int          st_t[$];
  logic [35:0] op_q[$];
  logic [15:0] exp_seq[$];

  // Record status changes with their cycle stamp, and every operand write
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (status !== last_st) begin
      st_q.push_back(status);
      st_t.push_back(cyc);
      last_st = status;
    end
    if (op_wr_en === 1'b1) op_q.push_back({op_addr, op_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic wait_ack(input logic v, input string tag);
    for (int k = 0; k < 300; k++) begin
      if (la_ack === v) break;
      @(negedge clk);
    end
    chk(tag, 32'(la_ack), 32'(v));
  endtask

  task automatic chk_reset_vals();
    chk("rst_status",     32'(status),     32'h0);
    chk("rst_test_id",    32'(test_id),    32'h0);
    chk("rst_ack",        32'(la_ack),     32'h0);
    chk("rst_data_o",     la_data_o,       32'h0);
    chk("rst_op_wr_en",   32'(op_wr_en),   32'h0);
    chk("rst_core_start", 32'(core_start), 32'h0);
    chk("rst_op_addr",    32'(op_addr),    32'h0);
    chk("rst_res_addr",   32'(res_addr),   32'h0);
  endtask

  task automatic do_reset(input logic hold_start);
    rst = 1'b1; la_start = hold_start; la_abort = 1'b0; la_req = 1'b0;
    la_data_i = '0; core_done = 1'b0; core_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_tid = 0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    la_start = 1'b1;
    repeat (2) @(negedge clk);
    la_start = 1'b0;
  endtask

  task automatic chk_seq();
    chk("seq_len", 32'(st_q.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++) begin
      logic [15:0] a;
      a = (i < st_q.size()) ? st_q[i] : 16'hFFFF;
      chk("status_seq", 32'(a), 32'(exp_seq[i]));
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N_IN; i++) in_words[i] = $urandom;
    for (int i = 0; i < 16; i++) res_mem[i] = $urandom;
  endtask

  // One CPU test: mode 0 = pass, 1 = core error, 2 = core never done
  task automatic run_test(input int mode, input int lat, input int abort_after, input bit rst_mid);
    int i42, i44;
    st_q.delete(); st_t.delete(); op_q.delete(); exp_seq.delete();
    pulse_start();
    for (int i = 0; i < N_IN; i++) begin
      if (i == abort_after) begin
        la_abort = 1'b1;
        @(negedge clk);
        la_abort = 1'b0;
        @(negedge clk);
        chk("abort_status", 32'(status), 32'hAB44);
        chk("abort_ack", 32'(la_ack), 32'h0);
        chk("abort_test_id", 32'(test_id), 32'(exp_tid));
        chk("abort_nwrites", 32'(op_q.size()), 32'(abort_after));
        exp_seq.push_back(16'hAB40); exp_seq.push_back(16'hAB41); exp_seq.push_back(16'hAB44);
        chk_seq();
        return;
      end
      la_data_i = in_words[i];
      la_req = 1'b1;
      wait_ack(1'b1, "rd_ack_hi");
      la_req = 1'b0;
      wait_ack(1'b0, "rd_ack_lo");
    end
    chk("op_nwrites", 32'(op_q.size()), 32'(N_IN));
    for (int i = 0; i < op_q.size() && i < N_IN; i++) begin
      logic [35:0] e;
      e = op_q[i];
      chk("op_addr", 32'(e[35:32]), 32'(i));
      chk("op_wdata", e[31:0], in_words[i]);
    end
    for (int k = 0; k < 20; k++) begin
      if (core_start === 1'b1) break;
      @(negedge clk);
    end
    chk("core_start", 32'(core_start), 32'h1);
    @(negedge clk);
    chk("core_start_pulse", 32'(core_start), 32'h0);
    if (mode != 2) begin
      repeat (lat) @(negedge clk);
      core_done = 1'b1;
      core_err  = (mode == 1);
      @(negedge clk);
      core_done = 1'b0;
      core_err  = 1'b0;
    end
    if (mode == 0) begin
      for (int i = 0; i < N_OUT; i++) begin
        wait_ack(1'b1, "wr_ack_hi");
        chk("res_data", la_data_o, res_mem[i]);
        if (rst_mid && i == 1) begin
          @(posedge clk);
          #3 rst = 1'b1;
          #1 chk_reset_vals();
          @(negedge clk);
          la_req = 1'b0;
          rst = 1'b0;
          exp_tid = 0;
          @(negedge clk);
          return;
        end
        la_req = 1'b1;
        wait_ack(1'b0, "wr_ack_lo");
        la_req = 1'b0;
      end
    end
    for (int k = 0; k < 400; k++) begin
      if (status == 16'hAB43 || status == 16'hAB44) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    exp_seq.push_back(16'hAB40); exp_seq.push_back(16'hAB41); exp_seq.push_back(16'hAB42);
    if (mode == 0) begin
      exp_seq.push_back(16'hAB51); exp_seq.push_back(16'hAB43);
    end else begin
      exp_seq.push_back(16'hAB44);
    end
    if (exp_tid == N_T - 1) exp_seq.push_back(16'hABFF);
    chk_seq();
    if (mode == 2) begin
      i42 = -1; i44 = -1;
      for (int i = 0; i < st_q.size(); i++) begin
        if (st_q[i] == 16'hAB42 && i42 < 0) i42 = i;
        if (st_q[i] == 16'hAB44 && i44 < 0) i44 = i;
      end
      chk("timeout_cycles", 32'((i42 >= 0 && i44 >= 0) ? st_t[i44] - st_t[i42] : -1), 32'(TMO));
    end
    exp_tid = (exp_tid == N_T - 1) ? exp_tid : exp_tid + 1;
    chk("test_id", 32'(test_id), 32'(exp_tid));
    chk("ack_idle", 32'(la_ack), 32'h0);
  endtask

  initial begin
    int mode, lat, ab;
    rst = 1'b0; la_start = 1'b0; la_abort = 1'b0; la_req = 1'b0;
    la_data_i = '0; core_done = 1'b0; core_err = 1'b0;
    for (int i = 0; i < 16; i++) res_mem[i] = '0;
    #1;

    // Reset with start held high: must not trigger afterwards
    do_reset(1'b1);
    chk_reset_vals();
    repeat (4) @(negedge clk);
    chk("start_held_no_trigger", 32'(status), 32'h0);
    la_start = 1'b0;
    @(negedge clk);

    // Directed pass (operands 1..8, done after 20), then core error -> finish
    for (int i = 0; i < N_IN; i++) in_words[i] = 32'(i + 1);
    for (int i = 0; i < 16; i++) res_mem[i] = $urandom;
    run_test(0, 20, -1, 1'b0);
    run_test(1, 5, -1, 1'b0);
    op_q.delete();
    pulse_start();
    repeat (5) @(negedge clk);
    chk("finish_status", 32'(status), 32'hABFF);
    chk("finish_test_id", 32'(test_id), 32'(N_T - 1));
    chk("finish_no_writes", 32'(op_q.size()), 32'h0);

    // Abort after 3 words, then timeout, then a pass ending in finish
    do_reset(1'b0);
    randomize_data();
    run_test(0, 0, 3, 1'b0);
    randomize_data();
    run_test(2, 0, -1, 1'b0);
    randomize_data();
    run_test(0, 7, -1, 1'b0);

    // Asynchronous reset in the middle of result readback
    do_reset(1'b0);
    randomize_data();
    run_test(0, 3, -1, 1'b1);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b0);
      for (int t = 0; t < 2; t++) begin
        randomize_data();
        mode = int'($urandom_range(0, 2));
        lat  = int'($urandom_range(0, 30));
        ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N_IN - 1)) : -1;
        run_test(mode, lat, ab, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bec_la_seq.md
BEC_LA_SEQ -- requirements
Module: bec_la_seq

Interface
REQ-001 Parameter N_IN_WORDS, default 8: operand words loaded from the CPU per test.
REQ-002 Parameter N_OUT_WORDS, default 4: result words returned to the CPU per test.
REQ-003 Parameter N_TESTS, default 10: tests per run before the final done code.
REQ-004 Parameter TIMEOUT_CYCLES, default 65535: maximum PROC cycles before failure.
REQ-005 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-007 la_start_i  in  1  CPU start level; rising edge requests a test.
REQ-008 la_abort_i  in  1  CPU abort; high for one cycle forces a return to IDLE.
REQ-009 la_req_i  in  1  CPU side of the 4-phase word handshake.
REQ-010 la_ack_o  out  1  block side of the 4-phase word handshake.
REQ-011 la_data_i  in  32  operand word from the CPU.
REQ-012 la_data_o  out  32  result word to the CPU.
REQ-013 status_o  out  16  progress code, routed to GPIO checkbits.
REQ-014 test_id_o  out  8  current test index, routed to GPIO.
REQ-015 op_wr_en_o / op_addr_o[3:0] / op_wdata_o[31:0]  out  operand write port to the BEC core.
REQ-016 core_start_o  out  1  one-cycle start pulse to the BEC core.
REQ-017 core_done_i / core_err_i  in  1 each  core completion and error, sampled together.
REQ-018 res_addr_o[3:0]  out, res_rdata_i[31:0]  in  core result read port; read is combinational (same-cycle).

Function
REQ-019 States: IDLE, START, READ, PROC, WRITE, RESULT, FINISH; state register only changes on a clock edge or async reset.
REQ-020 status_o per state: START AB40, READ AB41, PROC AB42, WRITE AB51, RESULT AB43 on pass / AB44 on fail, FINISH ABFF; IDLE holds the last value (0000 after reset).
REQ-021 IDLE: registered rising-edge detect on la_start_i -> START; la_start_i edges in any other state are ignored.
REQ-022 START lasts exactly one cycle -> READ; word counter cleared; fail flag cleared.
REQ-023 READ handshake: la_req_i=1 & la_ack_o=0 -> op_wr_en_o pulses one cycle with op_addr_o=count, op_wdata_o=la_data_i; la_ack_o set the same edge.
REQ-024 READ: la_req_i=0 & la_ack_o=1 -> la_ack_o cleared, count+1; when count reaches N_IN_WORDS -> PROC with core_start_o pulsed in the first PROC cycle.
REQ-025 PROC: cycle counter from 0; core_done_i=1 & core_err_i=0 -> WRITE; core_done_i=1 & core_err_i=1 -> RESULT(fail); counter reaching TIMEOUT_CYCLES without done -> RESULT(fail); done in the same cycle as timeout -> done wins.
REQ-026 WRITE: res_addr_o=count, la_data_o=res_rdata_i registered; la_ack_o=1 signals word valid; CPU la_req_i=1 consumes -> la_ack_o=0; la_req_i=0 -> count+1; after N_OUT_WORDS -> RESULT(pass).
REQ-027 RESULT lasts one cycle: test_id_o = N_TESTS-1 -> FINISH, otherwise test_id_o+1 -> IDLE.
REQ-028 FINISH is terminal until reset; all inputs are ignored.
REQ-029 la_abort_i in START/READ/PROC/WRITE -> IDLE next edge, status_o=AB44, la_ack_o=0, counters cleared, test_id_o unchanged; abort has priority over every other transition.
REQ-030 Counters wide enough for parameters; test_id_o wraps never (bounded by FINISH).

Reset
REQ-031 wb_rst_i=1 asynchronously forces IDLE, status_o=0000, test_id_o=0, la_ack_o=0, la_data_o=0, op_wr_en_o=0, core_start_o=0, all addresses/counters 0, edge detector primed to 1 (a start held high through reset does not trigger).

Structure
REQ-032 Shared package bec_pkg holds the state enum and the status code constants (AB40, AB41, AB42, AB51, AB43, AB44, ABFF).
REQ-033 One sub-module bec_la_hs: the 4-phase req/ack handshake engine, reused for READ and WRITE direction.

Verification
REQ-034 Reset, start, 8 operand words 0x1..0x8, core_done after 20 cycles, 4 result reads -> AB40,AB41,AB42,AB51,AB43 in order; op writes addr 0..7 data 1..8.
REQ-035 core_done_i with core_err_i=1 -> AB44, no WRITE, test_id_o 0->1.
REQ-036 TIMEOUT_CYCLES=100, core never done -> AB44 exactly 100 cycles after entering PROC.
REQ-037 la_abort_i after 3 READ words -> IDLE, AB44, la_ack_o=0; next start reloads from addr 0.
REQ-038 N_TESTS=2, two passing tests -> status ABFF, further starts ignored.
REQ-039 wb_rst_i asserted mid-WRITE, asynchronous to clock -> all outputs at reset values before next edge.
